// File: rtl/decode_queue_if.sv
// rtl/decode_queue_if.sv - fetch-side and execute-side handshakes of the decode queue
interface decode_queue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instruction;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1_address;
  logic [4:0]      out_rs2_address;
  logic [4:0]      out_rd_address;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_alu_operator;
  logic [1:0]      out_operand1_src;
  logic [2:0]      out_operand2_src;
  logic            out_pc_operand1_src;
  logic [1:0]      out_next_pc_src;
  logic [1:0]      out_reg_write_data_src;
  logic            out_reg_write_enable;
  logic            out_ram_write_enable;
  logic            out_stdout_write_enable;
  logic            out_illegal;

  modport master (
    output in_valid, in_instruction, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_address, out_rs2_address, out_rd_address,
           out_imm, out_alu_operator, out_operand1_src, out_operand2_src, out_pc_operand1_src,
           out_next_pc_src, out_reg_write_data_src, out_reg_write_enable, out_ram_write_enable,
           out_stdout_write_enable, out_illegal
  );

  modport slave (
    input  in_valid, in_instruction, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_address, out_rs2_address, out_rd_address,
           out_imm, out_alu_operator, out_operand1_src, out_operand2_src, out_pc_operand1_src,
           out_next_pc_src, out_reg_write_data_src, out_reg_write_enable, out_ram_write_enable,
           out_stdout_write_enable, out_illegal
  );
endinterface

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - FIFO-buffered RISC-V decode stage with a registered output slot
module decode_queue #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int ENABLE_STDIO = 1
) (
  input  logic         clk,
  input  logic         rstn,
  decode_queue_if.slave bus
);
  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3,
                         ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
                         ALU_OR = 5'd8, ALU_AND = 5'd9;
  localparam logic [1:0] OP1_RS1 = 2'd0, OP1_PC = 2'd1, OP1_ZERO = 2'd2;
  localparam logic [2:0] OP2_RS2 = 3'd0, OP2_IMM = 3'd1, OP2_FOUR = 3'd2, OP2_ZERO = 3'd3;
  localparam logic       PC_OP1_PC = 1'b0, PC_OP1_RS1 = 1'b1;
  localparam logic [1:0] NOT_BRANCH = 2'd0, BRANCH_ON_ZERO = 2'd1, BRANCH_ON_NONZERO = 2'd2,
                         BRANCH_ALWAYS = 2'd3;
  localparam logic [1:0] WB_ALU = 2'd0, WB_RAM = 2'd1, WB_STDIN = 2'd2;
  localparam int         AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [31:0]     fifo_inst [DEPTH];
  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count;

  logic fifo_empty, push, load_slot, bypass, pop, fifo_push;
  assign fifo_empty   = (count == '0);
  assign bus.in_ready = (count != FULL_COUNT) && !bus.flush;
  assign push         = bus.in_valid && bus.in_ready;
  assign load_slot    = !bus.out_valid || bus.out_ready;
  assign bypass       = push && fifo_empty && load_slot;
  assign pop          = load_slot && !fifo_empty;
  assign fifo_push    = push && !bypass;

  logic [31:0]     inst;
  logic [XLEN-1:0] dec_pc;
  assign inst   = fifo_empty ? bus.in_instruction : fifo_inst[rd_ptr];
  assign dec_pc = fifo_empty ? bus.in_pc : fifo_pc[rd_ptr];

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [4:0] alu_of(input logic [2:0] f3);
    case (f3)
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_iz, imm_s, imm_b, imm_u, imm_j;
  logic            shamt_ok;
  assign f3       = inst[14:12];
  assign imm_i    = sext({{20{inst[31]}}, inst[31:20]});
  assign imm_iz   = XLEN'(inst[31:20]);
  assign imm_s    = sext({{20{inst[31]}}, inst[31:25], inst[11:7]});
  assign imm_b    = sext({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
  assign imm_u    = sext({inst[31:12], 12'b0});
  assign imm_j    = sext({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
  // RV32 shifts have a 5-bit shamt, so bit 25 belongs to funct7 and must be clear
  assign shamt_ok = (XLEN == 64) || !inst[25];

  logic [4:0]      d_alu;
  logic [1:0]      d_op1, d_npc, d_wsrc;
  logic [2:0]      d_op2;
  logic            d_pcop1, d_rwe, d_mwe, d_swe, d_ill;
  logic [XLEN-1:0] d_imm;

  always_comb begin
    d_alu = ALU_ADD; d_op1 = OP1_RS1; d_op2 = OP2_RS2; d_pcop1 = PC_OP1_PC;
    d_npc = NOT_BRANCH; d_wsrc = WB_ALU; d_rwe = 1'b0; d_mwe = 1'b0; d_swe = 1'b0;
    d_imm = '0; d_ill = 1'b0;
    case (inst[6:0])
      7'b0110011: begin
        d_rwe = 1'b1; d_alu = alu_of(f3);
        if (inst[31:25] == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
          d_alu = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
        else if (inst[31:25] != 7'b0) d_ill = 1'b1;
      end
      7'b0010011: begin
        d_rwe = 1'b1; d_op2 = OP2_IMM; d_alu = alu_of(f3); d_imm = imm_i;
        case (f3)
          3'b011: d_imm = imm_iz;
          3'b001: begin
            d_imm = imm_iz;
            if (!(inst[31:26] == 6'b0 && shamt_ok)) d_ill = 1'b1;
          end
          3'b101: begin
            d_imm = imm_iz;
            if (inst[31:26] == 6'b010000 && shamt_ok) d_alu = ALU_SRA;
            else if (!(inst[31:26] == 6'b0 && shamt_ok)) d_ill = 1'b1;
          end
          default: ;
        endcase
      end
      7'b0000011: begin
        d_rwe = 1'b1; d_op2 = OP2_IMM; d_wsrc = WB_RAM; d_imm = imm_i;
        if (f3 == 3'b111 || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110))) d_ill = 1'b1;
      end
      7'b0100011: begin
        d_mwe = 1'b1; d_op2 = OP2_IMM; d_imm = imm_s;
        if (f3[2] || (XLEN == 32 && f3 == 3'b011)) d_ill = 1'b1;
      end
      // the ALU result is tested for zero/non-zero, so each compare maps to SUB/SLT/SLTU
      7'b1100011: begin
        d_imm = imm_b;
        case (f3)
          3'b000:  begin d_alu = ALU_SUB;  d_npc = BRANCH_ON_ZERO;    end
          3'b001:  begin d_alu = ALU_SUB;  d_npc = BRANCH_ON_NONZERO; end
          3'b100:  begin d_alu = ALU_SLT;  d_npc = BRANCH_ON_NONZERO; end
          3'b101:  begin d_alu = ALU_SLT;  d_npc = BRANCH_ON_ZERO;    end
          3'b110:  begin d_alu = ALU_SLTU; d_npc = BRANCH_ON_NONZERO; end
          3'b111:  begin d_alu = ALU_SLTU; d_npc = BRANCH_ON_ZERO;    end
          default: d_ill = 1'b1;
        endcase
      end
      7'b1101111: begin
        d_rwe = 1'b1; d_op1 = OP1_PC; d_op2 = OP2_FOUR; d_npc = BRANCH_ALWAYS; d_imm = imm_j;
      end
      7'b1100111: begin
        d_rwe = 1'b1; d_op1 = OP1_PC; d_op2 = OP2_FOUR; d_npc = BRANCH_ALWAYS;
        d_pcop1 = PC_OP1_RS1; d_imm = imm_i;
        if (f3 != 3'b000) d_ill = 1'b1;
      end
      7'b0110111: begin d_rwe = 1'b1; d_op1 = OP1_ZERO; d_op2 = OP2_IMM; d_imm = imm_u; end
      7'b0010111: begin d_rwe = 1'b1; d_op1 = OP1_PC;   d_op2 = OP2_IMM; d_imm = imm_u; end
      7'b0001011: begin
        if (ENABLE_STDIO == 0)   d_ill = 1'b1;
        else if (f3 == 3'b000) begin d_rwe = 1'b1; d_wsrc = WB_STDIN; end
        else if (f3 == 3'b001) begin d_swe = 1'b1; d_op2 = OP2_ZERO; end
        else                     d_ill = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_alu = ALU_ADD; d_op1 = OP1_RS1; d_op2 = OP2_RS2; d_pcop1 = PC_OP1_PC;
      d_npc = NOT_BRANCH; d_wsrc = WB_ALU; d_rwe = 1'b0; d_mwe = 1'b0; d_swe = 1'b0;
      d_imm = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_inst[wr_ptr] <= bus.in_instruction;
      fifo_pc[wr_ptr]   <= bus.in_pc;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0; wr_ptr <= '0; count <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0; wr_ptr <= '0; count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.out_valid <= 1'b0; bus.out_pc <= '0; bus.out_imm <= '0;
      bus.out_rs1_address <= '0; bus.out_rs2_address <= '0; bus.out_rd_address <= '0;
      bus.out_alu_operator <= ALU_ADD; bus.out_operand1_src <= OP1_RS1;
      bus.out_operand2_src <= OP2_RS2; bus.out_pc_operand1_src <= PC_OP1_PC;
      bus.out_next_pc_src <= NOT_BRANCH; bus.out_reg_write_data_src <= WB_ALU;
      bus.out_reg_write_enable <= 1'b0; bus.out_ram_write_enable <= 1'b0;
      bus.out_stdout_write_enable <= 1'b0; bus.out_illegal <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (bypass || pop) begin
      bus.out_valid <= 1'b1; bus.out_pc <= dec_pc; bus.out_imm <= d_imm;
      bus.out_rs1_address <= inst[19:15]; bus.out_rs2_address <= inst[24:20];
      bus.out_rd_address <= inst[11:7];
      bus.out_alu_operator <= d_alu; bus.out_operand1_src <= d_op1;
      bus.out_operand2_src <= d_op2; bus.out_pc_operand1_src <= d_pcop1;
      bus.out_next_pc_src <= d_npc; bus.out_reg_write_data_src <= d_wsrc;
      bus.out_reg_write_enable <= d_rwe; bus.out_ram_write_enable <= d_mwe;
      bus.out_stdout_write_enable <= d_swe; bus.out_illegal <= d_ill;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - scoreboard bench for decode_queue (RV32 with STDIO, RV64 without)
module tb_decode_queue;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  decode_queue_if #(.XLEN(32)) bus_a ();
  decode_queue_if #(.XLEN(64)) bus_b ();

  decode_queue #(.XLEN(32), .DEPTH(2), .ENABLE_STDIO(1)) dut_a (
    .clk(clk), .rstn(rstn), .bus(bus_a.slave));
  decode_queue #(.XLEN(64), .DEPTH(2), .ENABLE_STDIO(0)) dut_b (
    .clk(clk), .rstn(rstn), .bus(bus_b.slave));

  localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_SRA = 5'd7;
  localparam logic [1:0] O1_RS1 = 2'd0, O1_PC = 2'd1, O1_ZERO = 2'd2;
  localparam logic [2:0] O2_RS2 = 3'd0, O2_IMM = 3'd1, O2_FOUR = 3'd2, O2_ZERO = 3'd3;
  localparam logic [1:0] NB = 2'd0, BZ = 2'd1, JMP = 2'd3;
  localparam logic [1:0] W_ALU = 2'd0;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [4:0]  rd, rs1, rs2, alu;
    logic [1:0]  op1;
    logic [2:0]  op2;
    logic        pcop1;
    logic [1:0]  npc, wsrc;
    logic        rwe, mwe, swe, ill;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic exp_t mk(input logic [63:0] pc, imm, input logic [4:0] rd, rs1, rs2, alu,
                              input logic [1:0] op1, input logic [2:0] op2, input logic pcop1,
                              input logic [1:0] npc, wsrc, input logic rwe, mwe, swe, ill);
    exp_t e;
    e.pc = pc; e.imm = imm; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.alu = alu;
    e.op1 = op1; e.op2 = op2; e.pcop1 = pcop1; e.npc = npc; e.wsrc = wsrc;
    e.rwe = rwe; e.mwe = mwe; e.swe = swe; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t cap_a();
    return mk(64'(bus_a.out_pc), 64'(bus_a.out_imm), bus_a.out_rd_address,
              bus_a.out_rs1_address, bus_a.out_rs2_address, bus_a.out_alu_operator,
              bus_a.out_operand1_src, bus_a.out_operand2_src, bus_a.out_pc_operand1_src,
              bus_a.out_next_pc_src, bus_a.out_reg_write_data_src, bus_a.out_reg_write_enable,
              bus_a.out_ram_write_enable, bus_a.out_stdout_write_enable, bus_a.out_illegal);
  endfunction

  function automatic exp_t cap_b();
    return mk(bus_b.out_pc, bus_b.out_imm, bus_b.out_rd_address,
              bus_b.out_rs1_address, bus_b.out_rs2_address, bus_b.out_alu_operator,
              bus_b.out_operand1_src, bus_b.out_operand2_src, bus_b.out_pc_operand1_src,
              bus_b.out_next_pc_src, bus_b.out_reg_write_data_src, bus_b.out_reg_write_enable,
              bus_b.out_ram_write_enable, bus_b.out_stdout_write_enable, bus_b.out_illegal);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the RV32 instance: handshakes pop the scoreboard, stalls must hold fields
  logic hold_a = 1'b0;
  exp_t snap_a;
  always @(negedge clk) begin
    exp_t act, e;
    if (rstn) begin
      act = cap_a();
      if (hold_a && bus_a.out_valid) begin
        n_cmp++;
        if (act !== snap_a) begin
          n_bad++;
          $display("FAIL stall_hold_a: got %h expected %h", act, snap_a);
        end
      end
      if (bus_a.out_valid && bus_a.out_ready) begin
        n_cmp++;
        if (q_a.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out_a: got %h expected none", act);
        end else begin
          e = q_a.pop_front();
          e.pc  = {32'b0, e.pc[31:0]};
          e.imm = {32'b0, e.imm[31:0]};
          if (act !== e) begin
            n_bad++;
            $display("FAIL decode_a: got %h expected %h", act, e);
          end
        end
      end
      hold_a = bus_a.out_valid && !bus_a.out_ready && !bus_a.flush;
      snap_a = act;
    end else begin
      hold_a = 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t act, e;
    if (rstn && bus_b.out_valid && bus_b.out_ready) begin
      act = cap_b();
      n_cmp++;
      if (q_b.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out_b: got %h expected none", act);
      end else begin
        e = q_b.pop_front();
        if (act !== e) begin
          n_bad++;
          $display("FAIL decode_b: got %h expected %h", act, e);
        end
      end
    end
  end

  task automatic push_a(input logic [31:0] ins, input logic [31:0] pc, input exp_t e,
                        input bit track);
    int n = 0;
    bus_a.in_valid = 1'b1; bus_a.in_instruction = ins; bus_a.in_pc = pc;
    if (track) q_a.push_back(e);
    while (!bus_a.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("push_a_timeout", 64'(bus_a.in_ready), 64'd1);
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
  endtask

  task automatic push_b(input logic [31:0] ins, input logic [63:0] pc, input exp_t e);
    int n = 0;
    bus_b.in_valid = 1'b1; bus_b.in_instruction = ins; bus_b.in_pc = pc;
    q_b.push_back(e);
    while (!bus_b.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("push_b_timeout", 64'(bus_b.in_ready), 64'd1);
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin @(posedge clk); #1; n++; end
    chk(name, 64'(q_a.size() + q_b.size()), 64'd0);
  endtask

  exp_t e_addi, e_add, e_sub, e_sw;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    bus_a.in_valid = 0; bus_a.in_instruction = '0; bus_a.in_pc = '0;
    bus_a.flush = 0; bus_a.out_ready = 0;
    bus_b.in_valid = 0; bus_b.in_instruction = '0; bus_b.in_pc = '0;
    bus_b.flush = 0; bus_b.out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    chk("reset_in_ready", 64'(bus_a.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("reset_out_pc", 64'(bus_a.out_pc), 64'd0);
    chk("reset_out_imm", 64'(bus_a.out_imm), 64'd0);
    chk("reset_out_illegal", 64'(bus_a.out_illegal), 64'd0);
    @(posedge clk); #1;

    e_addi = mk(64'h100, 64'd5, 5'd1, 5'd0, 5'd5, A_ADD, O1_RS1, O2_IMM, 1'b0, NB, W_ALU, 1, 0, 0, 0);
    bus_a.out_ready = 1'b1;
    push_a(32'h00500093, 32'h100, e_addi, 1);
    chk("bypass_latency", 64'(bus_a.out_valid), 64'd1);
    push_a(32'hFE000EE3, 32'h104, mk(64'h104, 64'hFFFF_FFFF_FFFF_FFFC, 5'd29, 5'd0, 5'd0, A_SUB,
           O1_RS1, O2_RS2, 1'b0, BZ, W_ALU, 0, 0, 0, 0), 1);
    push_a(32'h123452B7, 32'h108, mk(64'h108, 64'h12345000, 5'd5, 5'd8, 5'd3, A_ADD,
           O1_ZERO, O2_IMM, 1'b0, NB, W_ALU, 1, 0, 0, 0), 1);
    push_a(32'hFFFFFFFF, 32'h10C, mk(64'h10C, 64'd0, 5'd31, 5'd31, 5'd31, A_ADD,
           O1_RS1, O2_RS2, 1'b0, NB, W_ALU, 0, 0, 0, 1), 1);
    push_a(32'h0000100B, 32'h110, mk(64'h110, 64'd0, 5'd0, 5'd0, 5'd0, A_ADD,
           O1_RS1, O2_ZERO, 1'b0, NB, W_ALU, 0, 0, 1, 0), 1);
    push_a(32'h010000EF, 32'h114, mk(64'h114, 64'd16, 5'd1, 5'd0, 5'd16, A_ADD,
           O1_PC, O2_FOUR, 1'b0, JMP, W_ALU, 1, 0, 0, 0), 1);
    push_a(32'h4032D293, 32'h118, mk(64'h118, 64'h403, 5'd5, 5'd5, 5'd3, A_SRA,
           O1_RS1, O2_IMM, 1'b0, NB, W_ALU, 1, 0, 0, 0), 1);
    push_a(32'h022081B3, 32'h11C, mk(64'h11C, 64'd0, 5'd3, 5'd1, 5'd2, A_ADD,
           O1_RS1, O2_RS2, 1'b0, NB, W_ALU, 0, 0, 0, 1), 1);
    push_a(32'h00002063, 32'h120, mk(64'h120, 64'd0, 5'd0, 5'd0, 5'd0, A_ADD,
           O1_RS1, O2_RS2, 1'b0, NB, W_ALU, 0, 0, 0, 1), 1);

    push_b(32'hFE000EE3, 64'h0000_0001_0000_0040, mk(64'h0000_0001_0000_0040,
           64'hFFFF_FFFF_FFFF_FFFC, 5'd29, 5'd0, 5'd0, A_SUB, O1_RS1, O2_RS2, 1'b0, BZ, W_ALU,
           0, 0, 0, 0));
    push_b(32'h0000100B, 64'h0000_0001_0000_0044, mk(64'h0000_0001_0000_0044, 64'd0,
           5'd0, 5'd0, 5'd0, A_ADD, O1_RS1, O2_RS2, 1'b0, NB, W_ALU, 0, 0, 0, 1));
    push_b(32'h800000B7, 64'h0000_0001_0000_0048, mk(64'h0000_0001_0000_0048,
           64'hFFFF_FFFF_8000_0000, 5'd1, 5'd0, 5'd0, A_ADD, O1_ZERO, O2_IMM, 1'b0, NB, W_ALU,
           1, 0, 0, 0));
    drain("drain_decode");

    // back-pressure: slot + two FIFO entries fill the queue, the fourth waits
    e_add = mk(64'h200, 64'd0, 5'd3, 5'd1, 5'd2, A_ADD, O1_RS1, O2_RS2, 1'b0, NB, W_ALU, 1, 0, 0, 0);
    e_sub = mk(64'h204, 64'd0, 5'd4, 5'd1, 5'd2, A_SUB, O1_RS1, O2_RS2, 1'b0, NB, W_ALU, 1, 0, 0, 0);
    e_sw  = mk(64'h208, 64'd8, 5'd8, 5'd1, 5'd2, A_ADD, O1_RS1, O2_IMM, 1'b0, NB, W_ALU, 0, 1, 0, 0);
    bus_a.out_ready = 1'b0;
    push_a(32'h002081B3, 32'h200, e_add, 1);
    chk("ready_after_1", 64'(bus_a.in_ready), 64'd1);
    push_a(32'h40208233, 32'h204, e_sub, 1);
    push_a(32'h0020A423, 32'h208, e_sw, 1);
    chk("full_in_ready", 64'(bus_a.in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("full_stays", 64'(bus_a.in_ready), 64'd0);
    bus_a.out_ready = 1'b1;
    e_addi.pc = 64'h20C;
    push_a(32'h00500093, 32'h20C, e_addi, 1);
    drain("drain_backpressure");

    // flush with three held
    bus_a.out_ready = 1'b0;
    push_a(32'h002081B3, 32'h300, e_add, 0);
    push_a(32'h40208233, 32'h304, e_sub, 0);
    push_a(32'h0020A423, 32'h308, e_sw, 0);
    bus_a.flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(bus_a.in_ready), 64'd0);
    @(posedge clk); #1;
    bus_a.flush = 1'b0;
    #1;
    chk("flush_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("flush_ready_back", 64'(bus_a.in_ready), 64'd1);
    bus_a.out_ready = 1'b1;
    e_addi.pc = 64'h30C;
    push_a(32'h00500093, 32'h30C, e_addi, 1);
    chk("post_flush_latency", 64'(bus_a.out_valid), 64'd1);
    drain("drain_flush");

    // asynchronous reset with entries queued
    bus_a.out_ready = 1'b0;
    push_a(32'h002081B3, 32'h400, e_add, 0);
    push_a(32'h40208233, 32'h404, e_sub, 0);
    push_a(32'h0020A423, 32'h408, e_sw, 0);
    #2 rstn = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("rst_out_pc", 64'(bus_a.out_pc), 64'd0);
    chk("rst_out_imm", 64'(bus_a.out_imm), 64'd0);
    chk("rst_ram_we", 64'(bus_a.out_ram_write_enable), 64'd0);
    @(posedge clk); #3 rstn = 1'b1;
    bus_a.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
    chk("rst_no_stale", 64'(bus_a.out_valid), 64'd0);
    e_addi.pc = 64'h500;
    push_a(32'h00500093, 32'h500, e_addi, 1);
    drain("drain_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
